// File: rtl/detector_jogada_debounce_if.sv
// Player-button bus between the game datapath and the debounce stage.
// The invalida signal exists only when INVALID_DETECT_EN is defined.
interface detector_jogada_debounce_if #(
    parameter int N_BOTOES = 4
);
    logic                habilita;
    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] jogada;
    logic                tem_jogada;
    logic [2:0]          db_estado;
`ifdef INVALID_DETECT_EN
    logic                invalida;

    modport master (output habilita, botoes, input jogada, tem_jogada, db_estado, invalida);
    modport slave  (input habilita, botoes, output jogada, tem_jogada, db_estado, invalida);
`else
    modport master (output habilita, botoes, input jogada, tem_jogada, db_estado);
    modport slave  (input habilita, botoes, output jogada, tem_jogada, db_estado);
`endif
endinterface

// File: rtl/detector_jogada_debounce.sv
// Synchronises and debounces raw buttons into one registered play code plus a one-cycle strobe.
// Optional INVALID_DETECT_EN rejects non-one-hot codes and pulses invalida instead.
module detector_jogada_debounce #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int RELEASE_CYCLES  = 5
) (
    input logic                      clock,
    input logic                      reset,
    detector_jogada_debounce_if.slave bus
);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [N_BOTOES-1:0] B_ZERO   = {N_BOTOES{1'b0}};

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        FILTRA      = 3'd1,
        PRESSIONADO = 3'd2,
        SOLTA       = 3'd3
    } estado_t;

    estado_t             r_estado, w_estado;
    logic [N_BOTOES-1:0] r_sinc1, r_sinc2;
    logic [N_BOTOES-1:0] r_amostra, w_amostra;
    logic [N_BOTOES-1:0] r_jogada, w_jogada;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_tem, w_tem;
`ifdef INVALID_DETECT_EN
    logic                r_invalida, w_invalida;

    function automatic logic um_quente(input logic [N_BOTOES-1:0] v);
        um_quente = (v != B_ZERO) && ((v & (v - N_BOTOES'(1))) == B_ZERO);
    endfunction
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_SAT) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sinc1 <= B_ZERO;
            r_sinc2 <= B_ZERO;
        end else begin
            r_sinc1 <= bus.botoes;
            r_sinc2 <= r_sinc1;
        end
    end

    // FSM state, sample, counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_amostra  <= B_ZERO;
            r_jogada   <= B_ZERO;
            r_cnt      <= CNT_ZERO;
            r_tem      <= 1'b0;
`ifdef INVALID_DETECT_EN
            r_invalida <= 1'b0;
`endif
        end else begin
            r_estado   <= w_estado;
            r_amostra  <= w_amostra;
            r_jogada   <= w_jogada;
            r_cnt      <= w_cnt;
            r_tem      <= w_tem;
`ifdef INVALID_DETECT_EN
            r_invalida <= w_invalida;
`endif
        end
    end

    // Next-state logic; strobes default low so they last a single cycle
    always_comb begin
        w_estado  = r_estado;
        w_amostra = r_amostra;
        w_jogada  = r_jogada;
        w_cnt     = r_cnt;
        w_tem     = 1'b0;
`ifdef INVALID_DETECT_EN
        w_invalida = 1'b0;
`endif
        case (r_estado)
            OCIOSO: begin
                if (bus.habilita && (r_sinc2 != B_ZERO)) begin
                    w_amostra = r_sinc2;
                    w_cnt     = CNT_ZERO;
                    w_estado  = FILTRA;
                end else begin
                    w_estado  = OCIOSO;
                end
            end
            FILTRA: begin
                if (r_sinc2 != r_amostra) begin
                    w_estado = OCIOSO;
                end else if (r_cnt == DEB_LAST) begin
`ifdef INVALID_DETECT_EN
                    if (um_quente(r_amostra)) begin
                        w_jogada = r_amostra;
                        w_tem    = 1'b1;
                    end else begin
                        w_invalida = 1'b1;
                    end
`else
                    w_jogada = r_amostra;
                    w_tem    = 1'b1;
`endif
                    w_estado = PRESSIONADO;
                end else begin
                    w_cnt = sat_inc(r_cnt);
                end
            end
            PRESSIONADO: begin
                // Other nonzero codes while held are deliberately ignored
                if (r_sinc2 == B_ZERO) begin
                    w_cnt    = CNT_ZERO;
                    w_estado = SOLTA;
                end else begin
                    w_estado = PRESSIONADO;
                end
            end
            SOLTA: begin
                if (r_sinc2 != B_ZERO) begin
                    w_estado = PRESSIONADO;
                end else if (r_cnt == REL_LAST) begin
                    w_estado = OCIOSO;
                end else begin
                    w_cnt = sat_inc(r_cnt);
                end
            end
            default: begin
                w_estado = OCIOSO;
            end
        endcase
    end

    assign bus.jogada     = r_jogada;
    assign bus.tem_jogada = r_tem;
    assign bus.db_estado  = r_estado;
`ifdef INVALID_DETECT_EN
    assign bus.invalida   = r_invalida;
`endif
endmodule

// File: tb/tb_detector_jogada_debounce.sv
// Directed bench for detector_jogada_debounce; INVALID_DETECT_EN adds the invalid-code scenario.
module tb_detector_jogada_debounce;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   strobes = 0;
    int   consec = 0;
    int   invs = 0;
    logic prev_tem = 1'b0;
    logic [2:0]  last_st = 3'd0;
    logic [31:0] trace = 32'd0;

    detector_jogada_debounce_if #(.N_BOTOES(4)) bif ();

    detector_jogada_debounce #(
        .N_BOTOES(4), .DEBOUNCE_CYCLES(5), .RELEASE_CYCLES(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bif)
    );

    always #5 clock = ~clock;

    // Advance n cycles, sampling on the falling edge and logging strobes and state changes
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (bif.tem_jogada === 1'b1) begin
                strobes++;
                if (prev_tem === 1'b1) consec++;
            end
            prev_tem = bif.tem_jogada;
`ifdef INVALID_DETECT_EN
            if (bif.invalida === 1'b1) invs++;
`endif
            if (bif.db_estado !== last_st) begin
                trace   = {trace[27:0], 1'b0, bif.db_estado};
                last_st = bif.db_estado;
            end
        end
    endtask

    task automatic begin_scenario();
        strobes  = 0;
        consec   = 0;
        invs     = 0;
        trace    = 32'd0;
        last_st  = bif.db_estado;
        prev_tem = bif.tem_jogada;
    endtask

    task automatic test_reset();
        bif.habilita = 1'b0;
        bif.botoes   = 4'b0000;
        reset = 1'b1;
        #3;
        checks++; if (bif.jogada !== 4'b0000) begin failures++; $display("FAIL reset_jogada got=%b exp=0000", bif.jogada); end
        checks++; if (bif.tem_jogada !== 1'b0) begin failures++; $display("FAIL reset_tem got=%b exp=0", bif.tem_jogada); end
        checks++; if (bif.db_estado !== 3'd0) begin failures++; $display("FAIL reset_estado got=%0d exp=0", bif.db_estado); end
        @(negedge clock);
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        begin_scenario();
        bif.habilita = 1'b1;
        bif.botoes   = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checks++;
            if (bif.tem_jogada !== ((k == 8) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL basic_latency edge=%0d got=%b exp=%b", k, bif.tem_jogada, (k == 8));
            end
        end
        bif.botoes = 4'b0000;
        step(10);
        checks++; if (strobes != 1) begin failures++; $display("FAIL basic_strobes got=%0d exp=1", strobes); end
        checks++; if (consec != 0) begin failures++; $display("FAIL basic_consec got=%0d exp=0", consec); end
        checks++; if (bif.jogada !== 4'b0001) begin failures++; $display("FAIL basic_jogada got=%b exp=0001", bif.jogada); end
        checks++; if (trace !== 32'h0001230) begin failures++; $display("FAIL basic_trace got=%h exp=0001230", trace); end
    endtask

    task automatic test_bounce();
        begin_scenario();
        for (int p = 0; p < 4; p++) begin
            bif.botoes = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            step(2);
        end
        bif.botoes = 4'b0100;
        step(10);
        checks++; if (strobes != 1) begin failures++; $display("FAIL bounce_strobes got=%0d exp=1", strobes); end
        checks++; if (bif.jogada !== 4'b0100) begin failures++; $display("FAIL bounce_jogada got=%b exp=0100", bif.jogada); end
        bif.botoes = 4'b0000;
        step(12);
        checks++; if (bif.db_estado !== 3'd0) begin failures++; $display("FAIL bounce_idle got=%0d exp=0", bif.db_estado); end
    endtask

    task automatic test_release_bounce();
        begin_scenario();
        bif.botoes = 4'b1000;
        step(10);
        bif.botoes = 4'b0000;
        step(2);
        bif.botoes = 4'b1000;
        step(1);
        bif.botoes = 4'b0000;
        step(10);
        checks++; if (strobes != 1) begin failures++; $display("FAIL relbounce_strobes got=%0d exp=1", strobes); end
        checks++; if (bif.jogada !== 4'b1000) begin failures++; $display("FAIL relbounce_jogada got=%b exp=1000", bif.jogada); end
        checks++; if (trace !== 32'h0123230) begin failures++; $display("FAIL relbounce_trace got=%h exp=0123230", trace); end
    endtask

    task automatic test_habilita();
        begin_scenario();
        bif.habilita = 1'b0;
        bif.botoes   = 4'b0010;
        step(10);
        checks++; if (strobes != 0) begin failures++; $display("FAIL hab_off_strobes got=%0d exp=0", strobes); end
        checks++; if (bif.jogada !== 4'b1000) begin failures++; $display("FAIL hab_off_jogada got=%b exp=1000", bif.jogada); end
        checks++; if (bif.db_estado !== 3'd0) begin failures++; $display("FAIL hab_off_estado got=%0d exp=0", bif.db_estado); end
        bif.habilita = 1'b1;
        step(2);
        bif.habilita = 1'b0;
        step(8);
        checks++; if (strobes != 1) begin failures++; $display("FAIL hab_on_strobes got=%0d exp=1", strobes); end
        checks++; if (bif.jogada !== 4'b0010) begin failures++; $display("FAIL hab_on_jogada got=%b exp=0010", bif.jogada); end
        bif.botoes = 4'b0000;
        step(12);
        bif.habilita = 1'b1;
    endtask

`ifdef INVALID_DETECT_EN
    task automatic test_invalid();
        begin_scenario();
        bif.habilita = 1'b1;
        bif.botoes   = 4'b0011;
        step(10);
        checks++; if (invs != 1) begin failures++; $display("FAIL inv_pulses got=%0d exp=1", invs); end
        checks++; if (strobes != 0) begin failures++; $display("FAIL inv_strobes got=%0d exp=0", strobes); end
        checks++; if (bif.jogada !== 4'b0010) begin failures++; $display("FAIL inv_jogada got=%b exp=0010", bif.jogada); end
        bif.botoes = 4'b0000;
        step(12);
        begin_scenario();
        bif.botoes = 4'b0001;
        step(10);
        checks++; if (strobes != 1) begin failures++; $display("FAIL inv_next_strobes got=%0d exp=1", strobes); end
        checks++; if (bif.jogada !== 4'b0001) begin failures++; $display("FAIL inv_next_jogada got=%b exp=0001", bif.jogada); end
        checks++; if (invs != 0) begin failures++; $display("FAIL inv_next_pulses got=%0d exp=0", invs); end
        bif.botoes = 4'b0000;
        step(12);
    endtask
`endif

    task automatic test_reset_mid();
        begin_scenario();
        bif.habilita = 1'b1;
        bif.botoes   = 4'b0001;
        step(5);
        checks++; if (bif.db_estado !== 3'd1) begin failures++; $display("FAIL mid_in_filtra got=%0d exp=1", bif.db_estado); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bif.jogada !== 4'b0000) begin failures++; $display("FAIL mid_async_jogada got=%b exp=0000", bif.jogada); end
        checks++; if (bif.db_estado !== 3'd0) begin failures++; $display("FAIL mid_async_estado got=%0d exp=0", bif.db_estado); end
        checks++; if (bif.tem_jogada !== 1'b0) begin failures++; $display("FAIL mid_async_tem got=%b exp=0", bif.tem_jogada); end
        bif.botoes = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        begin_scenario();
        step(12);
        checks++; if (strobes != 0) begin failures++; $display("FAIL mid_strobes got=%0d exp=0", strobes); end
        checks++; if (bif.db_estado !== 3'd0) begin failures++; $display("FAIL mid_estado got=%0d exp=0", bif.db_estado); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_release_bounce();
        test_habilita();
`ifdef INVALID_DETECT_EN
        test_invalid();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
